// File: rtl/gm_pkg.sv
// Shared types, default sizes and helpers for the gold-miner status logic.
package gm_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RUN    = 3'd1,
      PAUSED = 3'd2,
      WON    = 3'd3,
      LOST   = 3'd4
   } state_t;

   localparam int DEF_TICK_DIV   = 50000000;
   localparam int DEF_TIME_W     = 7;
   localparam int DEF_TIME_LIMIT = 60;
   localparam int DEF_SCORE_W    = 12;
   localparam int DEF_ADD_W      = 8;
   localparam int DEF_LEVEL_W    = 4;

   // min(a + b, 2^w - 1) for w <= 32
   function automatic logic [31:0] sat_add(
      input logic [31:0] a,
      input logic [31:0] b,
      input int          w
   );
      logic [32:0] s;
      logic [32:0] m;
      s = {1'b0, a} + {1'b0, b};
      m = (33'd1 << w) - 33'd1;
      return (s > m) ? m[31:0] : s[31:0];
   endfunction

endpackage

// File: rtl/level_status_tracker_if.sv
// Game-logic/HUD side bundle of the level status tracker.
interface level_status_tracker_if #(
   parameter int TIME_W  = gm_pkg::DEF_TIME_W,
   parameter int SCORE_W = gm_pkg::DEF_SCORE_W,
   parameter int ADD_W   = gm_pkg::DEF_ADD_W,
   parameter int LEVEL_W = gm_pkg::DEF_LEVEL_W
) ();

   logic               start;
   logic               pause;
   logic               add_valid;
   logic [ADD_W-1:0]   add_value;
   logic               bonus_valid;
   logic [TIME_W-1:0]  bonus_time;
   logic [SCORE_W-1:0] target_score;
   logic [SCORE_W-1:0] score;
   logic [TIME_W-1:0]  time_remain;
   logic [LEVEL_W-1:0] level;
   logic [2:0]         state;
   logic               tick;
   logic               level_won;
   logic               time_up;

   modport master (
      output start, pause, add_valid, add_value,
      output bonus_valid, bonus_time, target_score,
      input  score, time_remain, level, state,
      input  tick, level_won, time_up
   );

   modport slave (
      input  start, pause, add_valid, add_value,
      input  bonus_valid, bonus_time, target_score,
      output score, time_remain, level, state,
      output tick, level_won, time_up
   );

endinterface

// File: rtl/tick_prescaler.sv
// Counts enabled cycles 0..TICK_DIV-1 and pulses tick on the wrap cycle.
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = enable && (cnt_q == LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (clear || tick) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/level_status_tracker.sv
// Per-level score, countdown timer and level counter for the gold-miner game.
module level_status_tracker
   import gm_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int TIME_W     = DEF_TIME_W,
   parameter int TIME_LIMIT = DEF_TIME_LIMIT,
   parameter int SCORE_W    = DEF_SCORE_W,
   parameter int ADD_W      = DEF_ADD_W,
   parameter int LEVEL_W    = DEF_LEVEL_W
) (
   input logic clk,
   input logic resetn,
   level_status_tracker_if.slave bus
);

   localparam int TW1 = TIME_W + 1;
   localparam logic [TIME_W-1:0] T_LOAD = TIME_W'(TIME_LIMIT);

   state_t st_q, st_d;
   logic [SCORE_W-1:0] score_q, score_d, score_add;
   logic [TIME_W-1:0]  time_q, time_d, time_new;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [TW1-1:0]     t_sum, t_dec;
   logic               tick, run, active, go, win;

   assign run    = (st_q == RUN);
   assign active = run || (st_q == PAUSED);
   assign go     = bus.start && !active;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
      .clk    (clk),
      .resetn (resetn),
      .enable (run),
      .clear  (go),
      .tick   (tick)
   );

   assign score_add = bus.add_valid
      ? SCORE_W'(sat_add(32'(score_q), 32'(bus.add_value), SCORE_W))
      : score_q;
   assign win = (score_add >= bus.target_score);

   // bonus lands before the tick's decrement, so a last-second bonus saves the level
   assign t_sum = {1'b0, time_q}
      + (bus.bonus_valid ? {1'b0, bus.bonus_time} : '0);
   assign t_dec = (tick && t_sum != '0) ? t_sum - TW1'(1) : t_sum;
   assign time_new = t_dec[TIME_W] ? '1 : t_dec[TIME_W-1:0];

   always_comb begin
      st_d    = st_q;
      score_d = score_q;
      time_d  = time_q;
      level_d = level_q;
      unique case (st_q)
         IDLE: begin
            if (bus.start) begin
               st_d   = RUN;
               time_d = T_LOAD;
            end
         end
         RUN: begin
            score_d = score_add;
            time_d  = time_new;
            if (win)                st_d = WON;
            else if (time_q == '0)  st_d = LOST;
            else if (bus.pause)     st_d = PAUSED;
         end
         PAUSED: begin
            score_d = score_add;
            time_d  = time_new;
            if (!bus.pause) st_d = RUN;
         end
         WON: begin
            if (bus.start) begin
               st_d    = RUN;
               time_d  = T_LOAD;
               level_d = LEVEL_W'(sat_add(32'(level_q), 32'd1, LEVEL_W));
            end
         end
         LOST: begin
            if (bus.start) begin
               st_d    = RUN;
               time_d  = T_LOAD;
               score_d = '0;
               level_d = LEVEL_W'(1);
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q    <= IDLE;
         score_q <= '0;
         time_q  <= T_LOAD;
         level_q <= LEVEL_W'(1);
      end else begin
         st_q    <= st_d;
         score_q <= score_d;
         time_q  <= time_d;
         level_q <= level_d;
      end
   end

   assign bus.score       = score_q;
   assign bus.time_remain = time_q;
   assign bus.level       = level_q;
   assign bus.state       = st_q;
   assign bus.tick        = tick;
   assign bus.level_won   = (st_q == WON);
   assign bus.time_up     = (st_q == LOST);

endmodule
